// File: rtl/oam_dma_pkg.sv
// Shared console definitions used by the OAM DMA engine: OAM geometry,
// the DMA register address and the engine state encoding.
package oam_dma_pkg;

    localparam int unsigned OAM_SIZE     = 160;
    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam logic [7:0]  OAM_LAST     = 8'(OAM_SIZE - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_XFER  = 2'b10
    } oam_dma_state_e;

    // Pages 0xE0..0xFF alias onto WRAM 0xC0..0xDF when echo mapping is enabled.
    function automatic logic [7:0] echo_fold(input logic [7:0] page);
        return (page >= 8'hE0) ? (page - 8'h20) : page;
    endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: copies 160 bytes from {reg,8'h00} into OAM, one byte per ce.
// Optional build macro OAMDMA_ECHO_MAP_EN redirects echo-region sources to WRAM.
module oam_dma
    import oam_dma_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        reg_wr,
    input  logic [7:0]  wdata,
    output logic [7:0]  reg_rdata,
    output logic [15:0] dma_addr,
    input  logic [7:0]  dma_rdata,
    output logic        oam_we,
    output logic [7:0]  oam_waddr,
    output logic [7:0]  oam_wdata,
    output logic        oamdma
);

    oam_dma_state_e state_r, state_s;
    logic [7:0]     idx_r, idx_s;
    logic [7:0]     reg_r, reg_s;
    logic           restart_r, restart_s;
    logic           oamdma_r, oamdma_s;
    logic           xfer_we_s;
    logic [7:0]     base_hi_s;

`ifdef OAMDMA_ECHO_MAP_EN
    assign base_hi_s = echo_fold(reg_r);
`else
    assign base_hi_s = reg_r;
`endif

    // Next-state, write strobe and restart bookkeeping; a CPU write overrides progress.
    always_comb begin
        state_s   = state_r;
        idx_s     = idx_r;
        reg_s     = reg_r;
        restart_s = restart_r;
        xfer_we_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                restart_s = 1'b0;
            end
            ST_START: begin
                if (ce) begin
                    state_s   = ST_XFER;
                    restart_s = 1'b0;
                end else begin
                    state_s   = ST_START;
                end
            end
            ST_XFER: begin
                if (ce) begin
                    xfer_we_s = 1'b1;
                    if (idx_r == OAM_LAST) begin
                        state_s = ST_IDLE;
                        idx_s   = 8'd0;
                    end else begin
                        idx_s   = idx_r + 8'd1;
                    end
                end else begin
                    idx_s = idx_r;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                idx_s     = 8'd0;
                restart_s = 1'b0;
            end
        endcase
        // The byte of this cycle still lands; only the idx advance is superseded.
        if (reg_wr) begin
            reg_s     = wdata;
            idx_s     = 8'd0;
            state_s   = ST_START;
            restart_s = (state_r == ST_XFER) || ((state_r == ST_START) && restart_r);
        end else begin
            reg_s     = reg_s;
        end
        oamdma_s = (state_s == ST_XFER) || ((state_s == ST_START) && restart_s);
    end

    // State, index, register and busy flag storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            idx_r     <= 8'd0;
            reg_r     <= 8'hFF;
            restart_r <= 1'b0;
            oamdma_r  <= 1'b0;
        end else begin
            state_r   <= state_s;
            idx_r     <= idx_s;
            reg_r     <= reg_s;
            restart_r <= restart_s;
            oamdma_r  <= oamdma_s;
        end
    end

    assign reg_rdata = reg_r;
    assign oamdma    = oamdma_r;
    assign dma_addr  = (state_r == ST_XFER) ? ({base_hi_s, 8'h00} + {8'h00, idx_r}) : 16'h0000;
    assign oam_we    = xfer_we_s;
    assign oam_waddr = idx_r;
    assign oam_wdata = xfer_we_s ? dma_rdata : 8'h00;

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: directed scenarios plus random traffic,
// compared cycle by cycle against a transfer-level reference model.
module tb_oam_dma;

    localparam int OAM_N = 160;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        reg_wr;
    logic [7:0]  wdata;
    logic [7:0]  reg_rdata;
    logic [15:0] dma_addr;
    logic [7:0]  dma_rdata;
    logic        oam_we;
    logic [7:0]  oam_waddr;
    logic [7:0]  oam_wdata;
    logic        oamdma;

    int total = 0;
    int bad   = 0;
    int n_writes = 0;

    // Reference model: a pending transfer waits m_wait ce strobes, then writes m_count..159.
    logic [7:0] m_reg;
    bit         m_busy;
    int         m_wait;
    int         m_count;
    bit         m_restart;

    oam_dma dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .reg_wr    (reg_wr),
        .wdata     (wdata),
        .reg_rdata (reg_rdata),
        .dma_addr  (dma_addr),
        .dma_rdata (dma_rdata),
        .oam_we    (oam_we),
        .oam_waddr (oam_waddr),
        .oam_wdata (oam_wdata),
        .oamdma    (oamdma)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    assign dma_rdata = mem_byte(dma_addr);

    function automatic logic [15:0] m_base();
        int page;
        page = int'(m_reg);
`ifdef OAMDMA_ECHO_MAP_EN
        if (page >= 224) page = page - 32;
`endif
        return 16'(page * 256);
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_reg = 8'hFF; m_busy = 0; m_wait = 0; m_count = 0; m_restart = 0;
    endtask

    // One clock: drive at posedge+1, check at negedge, advance model after posedge.
    task automatic step(input logic c, input logic w, input logic [7:0] d);
        bit          e_xfer, e_we, e_dma;
        logic [15:0] e_addr;
        ce = c; reg_wr = w; wdata = d;
        @(negedge clk);
        e_xfer = m_busy && (m_wait == 0);
        e_we   = c && e_xfer;
        e_addr = e_xfer ? (m_base() + 16'(m_count)) : 16'h0000;
        e_dma  = m_busy && ((m_wait == 0) || m_restart);
        check("oam_we",    16'(oam_we),    16'(e_we));
        check("dma_addr",  dma_addr,       e_addr);
        check("oamdma",    16'(oamdma),    16'(e_dma));
        check("reg_rdata", 16'(reg_rdata), 16'(m_reg));
        if (e_we) begin
            check("oam_waddr", 16'(oam_waddr), 16'(m_count));
            check("oam_wdata", 16'(oam_wdata), 16'(mem_byte(e_addr)));
        end
        if (oam_we) n_writes++;
        @(posedge clk); #1;
        if (e_we) begin
            m_count++;
            if (m_count == OAM_N) begin m_busy = 0; m_count = 0; end
        end else if (c && m_busy && m_wait > 0) begin
            m_wait--;
        end
        if (w) begin
            m_restart = e_dma; m_reg = d; m_busy = 1; m_wait = 1; m_count = 0;
        end else if (m_wait == 0) begin
            m_restart = 0;
        end
    endtask

    task automatic run_done(input int period, input int max_clk);
        int k;
        k = 0;
        while (m_busy && k < max_clk) begin
            step((k % period) == 0, 1'b0, 8'h00);
            k++;
        end
        check("xfer_end", 16'(oamdma), 16'h0000);
    endtask

    task automatic run_to_idx(input int n, input int max_clk);
        int k;
        k = 0;
        while (m_count != n && k < max_clk) begin
            step(1'b1, 1'b0, 8'h00);
            k++;
        end
        check("reach_idx", 16'(dma_addr[7:0]), 16'(n));
    endtask

    initial begin
        int n0;
        logic [15:0] a0;
        reset = 1'b1; ce = 1'b0; reg_wr = 1'b0; wdata = 8'h00;
        model_reset();
        #1;
        check("rst_oamdma",    16'(oamdma),    16'h0000);
        check("rst_oam_we",    16'(oam_we),    16'h0000);
        check("rst_dma_addr",  dma_addr,       16'h0000);
        check("rst_reg_rdata", 16'(reg_rdata), 16'h00FF);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) step(1'b1, 1'b0, 8'h00);

        // Plain transfer, ce every 4 clk
        n0 = n_writes;
        step(1'b0, 1'b1, 8'hC1);
        run_done(4, 800);
        check("writes_c1", 16'(n_writes - n0), 16'(OAM_N));

        // Restart at idx 50 with a coincident ce
        step(1'b0, 1'b1, 8'h80);
        run_to_idx(50, 100);
        step(1'b1, 1'b1, 8'hC0);
        n0 = n_writes;
        run_done(1, 400);
        check("writes_after_restart", 16'(n_writes - n0), 16'(OAM_N));

        // Echo page source
        step(1'b0, 1'b1, 8'hFE);
        step(1'b1, 1'b0, 8'h00);
`ifdef OAMDMA_ECHO_MAP_EN
        check("echo_base", dma_addr, 16'hDE00);
`else
        check("echo_base", dma_addr, 16'hFE00);
`endif
        run_done(1, 400);

        // reg_wr coincident with ce in START
        step(1'b0, 1'b1, 8'h44);
        n0 = n_writes;
        step(1'b1, 1'b1, 8'h45);
        step(1'b1, 1'b0, 8'h00);
        check("start_hold_nowrite", 16'(n_writes - n0), 16'h0000);
        step(1'b1, 1'b0, 8'h00);
        check("start_hold_first", 16'(n_writes - n0), 16'h0001);
        run_done(1, 400);

        // ce gap during XFER
        step(1'b0, 1'b1, 8'h12);
        run_to_idx(30, 100);
        a0 = dma_addr;
        n0 = n_writes;
        repeat (20) step(1'b0, 1'b0, 8'h00);
        check("gap_addr", dma_addr, a0);
        check("gap_writes", 16'(n_writes - n0), 16'h0000);
        run_done(1, 400);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 199) == 0), 8'($urandom));
        end
        run_done(1, 400);

        // Reset at idx 100
        step(1'b0, 1'b1, 8'h33);
        run_to_idx(100, 200);
        ce = 1'b1; reg_wr = 1'b0; reset = 1'b1;
        #1;
        check("abort_oamdma",    16'(oamdma),    16'h0000);
        check("abort_oam_we",    16'(oam_we),    16'h0000);
        check("abort_reg_rdata", 16'(reg_rdata), 16'h00FF);
        check("abort_dma_addr",  dma_addr,       16'h0000);
        check("abort_waddr",     16'(oam_waddr), 16'h0000);
        check("abort_wdata",     16'(oam_wdata), 16'h0000);
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        n0 = n_writes;
        repeat (200) step(1'b1, 1'b0, 8'h00);
        check("no_writes_after_reset", 16'(n_writes - n0), 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
